mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data/instruction memory port between the instruction fetch path and the load/store path of the 3-stage pipeline. Each cycle it grants at most one requester, drives the memory port from the winner, and routes the read data returned MEM_LATENCY cycles later to the requester that issued the access. Fixed priority favours data accesses. A starvation counter guarantees fetch progress.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from an accepted memory request to valid mem_rdata_i; legal range 1..4.
- STARVE_LIMIT, 4: consecutive lost fetch arbitrations after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held until granted.
- if_addr_i  in  32  fetch address.
- if_gnt_o  out  1  fetch granted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  32  fetch read data.
- d_req_i  in  1  load/store request; held until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data, already byte-replicated.
- d_be_i  in  4  store byte enables.
- d_gnt_o  out  1  data granted this cycle.
- d_rvalid_o  out  1  load data valid; never asserted for stores.
- d_rdata_o  out  32  load data, raw word.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  write strobe.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables; 4'b1111 for fetch and loads.
- mem_rdata_i  in  32  read data, valid MEM_LATENCY cycles after the request.

## Operation
- Arbitration is combinational on the current requests and the starvation state. The winner is:
  - none, if neither requests;
  - the sole requester, if only one requests;
  - data, if both request and starve_cnt < STARVE_LIMIT;
  - fetch, if both request and starve_cnt == STARVE_LIMIT.
- Exactly one of if_gnt_o / d_gnt_o is high when mem_req_o is high. Both are low otherwise.
- Memory port is driven from the winner.
  - Fetch: mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0.
  - Data: mem_we_o=d_we_i, mem_be_o = d_we_i ? d_be_i : 4'b1111, data fields passed through.
  - Idle: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
- starve_cnt is a 4-bit register.
  - Increments (saturating at STARVE_LIMIT) when if_req_i && d_gnt_o.
  - Clears when if_gnt_o or !if_req_i.
  - Holds otherwise.
- Response tracking is a MEM_LATENCY-deep shift register of tags {valid, owner}.
  - A tag is pushed every cycle: valid = mem_req_o && !mem_we_o, owner = fetch/data.
  - At the output stage, if_rvalid_o = valid && owner==fetch, and d_rvalid_o = valid && owner==data.
- if_rdata_o and d_rdata_o both carry mem_rdata_i. Consumers qualify with rvalid.
- A requester may change its request only after its grant. The block does not check this.

## Timing
- Grant is in the same cycle as the request when the requester wins; memory access occurs in that cycle.
- A read granted in cycle N gives rvalid in cycle N+MEM_LATENCY, exactly one cycle wide.
- Back-to-back grants give back-to-back rvalids in grant order. One access per cycle sustains full throughput.
- if_rvalid_o and d_rvalid_o are never high in the same cycle.
- Reset values:
  - All tag valids are 0 and starve_cnt is 0.
  - if_rvalid_o and d_rvalid_o are 0.
  - Grants and mem_* follow their combinational rules with the reset state. With no requests, all are 0.
- Reset asserted mid-operation discards all in-flight tags. No rvalid is issued for reads accepted before or during the reset cycle.
- Simultaneous store grant and pending read return: the store issues normally and the returning rvalid is unaffected.
- A store pushes an invalid tag, so the response timing of later reads is unchanged.

## Test plan
- Fetch only: if_req_i held for 3 cycles with addr 0x0,0x4,0x8 (MEM_LATENCY=1).
  - Required: if_gnt_o=1 for all 3 cycles.
  - Required: if_rvalid_o high in cycles 2–4 with the matching mem_rdata_i.
  - Required: d_rvalid_o=0 throughout.
- Contention with STARVE_LIMIT=4: both requests held for 5 cycles.
  - Required: d_gnt_o for 4 cycles, then if_gnt_o in the 5th cycle.
  - Required: starve_cnt returns to 0 after the fetch grant.
- Store: d_req_i with d_we_i=1, addr 0x100, be 4'b0100, wdata 0xAAAAAAAA.
  - Required: mem_we_o=1, mem_be_o=4'b0100, mem_addr_o=0x100.
  - Required: no d_rvalid_o in any later cycle.
- Interleaved reads with MEM_LATENCY=3: grants in order data, fetch, data.
  - Required: rvalids 3 cycles later in order d, if, d, never overlapping.
- Reset mid-flight: two loads granted with MEM_LATENCY=2, then reset pulsed for 1 cycle before the first return.
  - Required: no rvalid is seen, and all outputs are idle after the reset cycle.
- Idle: no requests for 10 cycles.
  - Required: mem_req_o=0 and all grants and rvalids are 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and load/store.
//   Data wins by default; after STARVE_LIMIT consecutive lost arbitrations
//   fetch is forced through. Reads are tagged with their owner in a
//   MEM_LATENCY-deep pipeline so returning data is steered back correctly.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   if_req_i/if_addr_i            fetch request and address
//   if_gnt_o                      fetch won arbitration this cycle
//   if_rvalid_o/if_rdata_o        fetch read return
//   d_req_i/d_we_i/d_addr_i       load/store request, store flag, address
//   d_wdata_i/d_be_i              store data and byte enables
//   d_gnt_o                       load/store won arbitration this cycle
//   d_rvalid_o/d_rdata_o          load read return (never for stores)
//   mem_req_o/mem_we_o/mem_addr_o memory request, write strobe, address
//   mem_wdata_o/mem_be_o          memory write data and byte enables
//   mem_rdata_i                   memory read data, MEM_LATENCY cycles later
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]                r_starve_cnt;
  tag_t [MEM_LATENCY-1:0]    r_tags;
  tag_t                      w_push;
  tag_t                      w_ret;
  logic                      w_force_if;
  logic                      w_if_win;
  logic                      w_d_win;

  assign w_force_if = (r_starve_cnt == LP_LIMIT);
  assign w_if_win   = if_req_i && (!d_req_i || w_force_if);
  assign w_d_win    = d_req_i && !w_if_win;

  // NOTE: every output of this block gets a default before the branches;
  // a missing default on any path would infer a latch.
  always_comb begin
    if_gnt_o    = w_if_win;
    d_gnt_o     = w_d_win;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'b0000;
    if (w_if_win) begin
      mem_req_o  = 1'b1;
      mem_addr_o = if_addr_i;
      mem_be_o   = 4'b1111;
    end else if (w_d_win) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_we_i ? d_be_i : 4'b1111;
    end
  end

  // Fetch loses only when data wins against a pending fetch; anything else
  // (fetch served, or no fetch waiting) restarts the count.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_if_win || !if_req_i) begin
      r_starve_cnt <= 4'd0;
    end else if (w_d_win && r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // A tag enters every cycle; stores and idle cycles push an invalid tag
  // so later reads keep their fixed return slot.
  always_comb begin
    w_push       = '0;
    w_push.valid = mem_req_o && !mem_we_o;
    w_push.owner = w_if_win ? OWN_FETCH : OWN_DATA;
  end

  // The tag pipeline is small control state, so it is cleared on reset to
  // drop every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tags <= '0;
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        r_tags[i] <= r_tags[i-1];
      end
      r_tags[0] <= w_push;
    end
  end

  // Returns are masked while reset is asserted so reads accepted before the
  // reset cycle never surface.
  assign w_ret       = r_tags[MEM_LATENCY-1];
  assign if_rvalid_o = !reset && w_ret.valid && (w_ret.owner == OWN_FETCH);
  assign d_rvalid_o  = !reset && w_ret.valid && (w_ret.owner == OWN_DATA);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Three instances share stimulus:
//   u0: MEM_LATENCY=1, STARVE_LIMIT=4
//   u1: MEM_LATENCY=2, STARVE_LIMIT=4
//   u2: MEM_LATENCY=3, STARVE_LIMIT=1
// A cycle-indexed history of issued reads per instance predicts returns.
module tb_mem_port_arbiter;

  localparam int NI   = 3;
  localparam int MAXC = 4096;

  int lat [NI] = '{1, 2, 3};
  int lim [NI] = '{4, 4, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if;
  logic [31:0] addr_if;
  logic        req_d;
  logic        we_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic [31:0] rdata_m;

  logic [NI-1:0] o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_mreq, o_mwe;
  logic [31:0]   o_if_rd [NI];
  logic [31:0]   o_d_rd  [NI];
  logic [31:0]   o_maddr [NI];
  logic [31:0]   o_mwd   [NI];
  logic [3:0]    o_mbe   [NI];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int starve [NI];
  int hist [NI][MAXC];   // 0 none, 1 fetch read, 2 data read
  logic last_if_gnt0;
  logic last_d_gnt0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .reset(rst),
    .if_req_i(req_if), .if_addr_i(addr_if), .if_gnt_o(o_if_gnt[0]),
    .if_rvalid_o(o_if_rv[0]), .if_rdata_o(o_if_rd[0]),
    .d_req_i(req_d), .d_we_i(we_d), .d_addr_i(addr_d), .d_wdata_i(wdata_d),
    .d_be_i(be_d), .d_gnt_o(o_d_gnt[0]), .d_rvalid_o(o_d_rv[0]),
    .d_rdata_o(o_d_rd[0]), .mem_req_o(o_mreq[0]), .mem_we_o(o_mwe[0]),
    .mem_addr_o(o_maddr[0]), .mem_wdata_o(o_mwd[0]), .mem_be_o(o_mbe[0]),
    .mem_rdata_i(rdata_m));

  mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .reset(rst),
    .if_req_i(req_if), .if_addr_i(addr_if), .if_gnt_o(o_if_gnt[1]),
    .if_rvalid_o(o_if_rv[1]), .if_rdata_o(o_if_rd[1]),
    .d_req_i(req_d), .d_we_i(we_d), .d_addr_i(addr_d), .d_wdata_i(wdata_d),
    .d_be_i(be_d), .d_gnt_o(o_d_gnt[1]), .d_rvalid_o(o_d_rv[1]),
    .d_rdata_o(o_d_rd[1]), .mem_req_o(o_mreq[1]), .mem_we_o(o_mwe[1]),
    .mem_addr_o(o_maddr[1]), .mem_wdata_o(o_mwd[1]), .mem_be_o(o_mbe[1]),
    .mem_rdata_i(rdata_m));

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(1)) u2 (
    .clk(clk), .reset(rst),
    .if_req_i(req_if), .if_addr_i(addr_if), .if_gnt_o(o_if_gnt[2]),
    .if_rvalid_o(o_if_rv[2]), .if_rdata_o(o_if_rd[2]),
    .d_req_i(req_d), .d_we_i(we_d), .d_addr_i(addr_d), .d_wdata_i(wdata_d),
    .d_be_i(be_d), .d_gnt_o(o_d_gnt[2]), .d_rvalid_o(o_d_rv[2]),
    .d_rdata_o(o_d_rd[2]), .mem_req_o(o_mreq[2]), .mem_we_o(o_mwe[2]),
    .mem_addr_o(o_maddr[2]), .mem_wdata_o(o_mwd[2]), .mem_be_o(o_mbe[2]),
    .mem_rdata_i(rdata_m));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Who wins for instance k with the current requests and modelled count.
  function automatic logic fetch_wins(int k);
    return req_if && (!req_d || starve[k] == lim[k]);
  endfunction

  function automatic logic data_wins(int k);
    return req_d && !fetch_wins(k);
  endfunction

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic        fi, fd, ev_if, ev_d;
      logic [3:0]  ebe;
      logic [31:0] eaddr, ewd;
      int          code;
      fi    = fetch_wins(k);
      fd    = data_wins(k);
      ebe   = fi ? 4'hF : (fd ? (we_d ? be_d : 4'hF) : 4'h0);
      eaddr = fi ? addr_if : (fd ? addr_d : 32'h0);
      ewd   = fd ? wdata_d : 32'h0;
      code  = (rst || cyc < lat[k]) ? 0 : hist[k][cyc - lat[k]];
      ev_if = (code == 1);
      ev_d  = (code == 2);
      check($sformatf("if_gnt[%0d]", k), 32'(o_if_gnt[k]), 32'(fi));
      check($sformatf("d_gnt[%0d]", k), 32'(o_d_gnt[k]), 32'(fd));
      check($sformatf("mem_req[%0d]", k), 32'(o_mreq[k]), 32'(fi || fd));
      check($sformatf("mem_we[%0d]", k), 32'(o_mwe[k]), 32'(fd && we_d));
      check($sformatf("mem_be[%0d]", k), 32'(o_mbe[k]), 32'(ebe));
      check($sformatf("mem_addr[%0d]", k), o_maddr[k], eaddr);
      check($sformatf("mem_wdata[%0d]", k), o_mwd[k], ewd);
      check($sformatf("if_rvalid[%0d]", k), 32'(o_if_rv[k]), 32'(ev_if));
      check($sformatf("d_rvalid[%0d]", k), 32'(o_d_rv[k]), 32'(ev_d));
      check($sformatf("rv_overlap[%0d]", k), 32'(o_if_rv[k] && o_d_rv[k]), 32'd0);
      if (ev_if) check($sformatf("if_rdata[%0d]", k), o_if_rd[k], rdata_m);
      if (ev_d)  check($sformatf("d_rdata[%0d]", k), o_d_rd[k], rdata_m);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  // Close the current cycle: record issued reads, update starvation counts.
  task automatic advance();
    @(posedge clk);
    last_if_gnt0 = fetch_wins(0);
    last_d_gnt0  = data_wins(0);
    for (int k = 0; k < NI; k++) begin
      logic fi, fd;
      fi = fetch_wins(k);
      fd = data_wins(k);
      hist[k][cyc] = fi ? 1 : ((fd && !we_d) ? 2 : 0);
      if (rst) begin
        starve[k] = 0;
        for (int j = 0; j < lat[k]; j++)
          if (cyc - j >= 0) hist[k][cyc - j] = 0;
      end else if (fi || !req_if) begin
        starve[k] = 0;
      end else if (fd && starve[k] < lim[k]) begin
        starve[k] = starve[k] + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; req_if = 1'b0; req_d = 1'b0; we_d = 1'b0;
    addr_if = '0; addr_d = '0; wdata_d = '0; be_d = '0;
    rdata_m = $urandom;
  endtask

  task automatic run_idle(int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      sample();
      advance();
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      starve[k] = 0;
      for (int c = 0; c < MAXC; c++) hist[k][c] = 0;
    end
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, then a quiet cycle.
    for (int i = 0; i < 2; i++) begin
      set_idle(); rst = 1'b1;
      sample();
      check("reset_rv", 32'(o_if_rv | o_d_rv), 32'd0);
      advance();
    end
    run_idle(1);

    // Fetch only on u0 (latency 1): grants 3 cycles, returns one later.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      req_if  = (i < 3);
      addr_if = 32'(4 * i);
      sample();
      check("fo_if_gnt", 32'(o_if_gnt[0]), 32'(i < 3));
      check("fo_if_rv", 32'(o_if_rv[0]), 32'(i >= 1 && i <= 3));
      check("fo_d_rv", 32'(o_d_rv[0]), 32'd0);
      advance();
    end

    // Contention on u0 (limit 4): four data wins, then fetch, then data again.
    for (int i = 0; i < 7; i++) begin
      set_idle();
      req_if  = (i <= 5);
      addr_if = 32'h1000 + 32'(4 * i);
      req_d   = (i <= 5);
      addr_d  = 32'h2000 + 32'(4 * i);
      sample();
      check("ct_d_gnt", 32'(o_d_gnt[0]), 32'(i < 4 || i == 5));
      check("ct_if_gnt", 32'(o_if_gnt[0]), 32'(i == 4));
      advance();
    end
    run_idle(3);

    // Store: byte-lane write, never produces a data return.
    set_idle();
    req_d = 1'b1; we_d = 1'b1; addr_d = 32'h100; be_d = 4'b0100;
    wdata_d = 32'hAAAA_AAAA;
    sample();
    check("st_we", 32'(o_mwe[0]), 32'd1);
    check("st_be", 32'(o_mbe[0]), 32'h4);
    check("st_addr", o_maddr[0], 32'h100);
    check("st_wdata", o_mwd[0], 32'hAAAA_AAAA);
    advance();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      sample();
      check("st_no_drv", 32'(o_d_rv), 32'd0);
      advance();
    end

    // Interleaved reads on u2 (latency 3): d, if, d return in that order.
    for (int i = 0; i < 7; i++) begin
      set_idle();
      req_d   = (i == 0 || i == 2);
      addr_d  = 32'h300 + 32'(i);
      req_if  = (i == 1);
      addr_if = 32'h400;
      sample();
      check("il_d_rv", 32'(o_d_rv[2]), 32'(i == 3 || i == 5));
      check("il_if_rv", 32'(o_if_rv[2]), 32'(i == 4));
      advance();
    end

    // Reset mid-flight on u1 (latency 2): two loads, reset with the second.
    for (int i = 0; i < 7; i++) begin
      set_idle();
      req_d  = (i <= 1);
      addr_d = 32'h500 + 32'(4 * i);
      rst    = (i == 1);
      sample();
      check("rm_rv", 32'(o_if_rv[1] || o_d_rv[1]), 32'd0);
      if (i >= 2) begin
        check("rm_idle_req", 32'(o_mreq), 32'd0);
        check("rm_idle_gnt", 32'(o_if_gnt | o_d_gnt), 32'd0);
      end
      advance();
    end

    // Idle stretch.
    for (int i = 0; i < 10; i++) begin
      set_idle();
      sample();
      check("idle_req", 32'(o_mreq | o_if_gnt | o_d_gnt), 32'd0);
      check("idle_rv", 32'(o_if_rv | o_d_rv), 32'd0);
      advance();
    end

    // Random traffic; requests held until u0 grants them.
    req_if = 1'b0; req_d = 1'b0;
    last_if_gnt0 = 1'b0; last_d_gnt0 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (!req_if || last_if_gnt0) begin
        req_if  = ($urandom_range(0, 99) < 60);
        addr_if = $urandom & 32'hFFFF_FFFC;
      end
      if (!req_d || last_d_gnt0) begin
        req_d   = ($urandom_range(0, 99) < 60);
        we_d    = $urandom_range(0, 1) == 1;
        addr_d  = $urandom;
        wdata_d = $urandom;
        be_d    = 4'($urandom);
      end
      rst     = ($urandom_range(0, 79) == 0);
      rdata_m = $urandom;
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
